// File: rtl/adder32_accum.sv
// Packet accumulator: sums a stream of 32-bit operands through the shared ripple adder
// and reports sum, carry-out count, beat count and truncation once per packet.
`timescale 1ns/1ps

module adder32 (
  output logic [31:0] s,
  output logic        co,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci
);
  logic [32:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co = c[32];
endmodule

module adder32_accum #(
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic [7:0]  out_carries,
  output logic [7:0]  out_count,
  output logic        out_trunc
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [7:0]  carries_reg, carries_next;
  logic [7:0]  count_reg, count_next;
  logic [31:0] out_sum_reg, out_sum_next;
  logic [7:0]  out_carries_reg, out_carries_next;
  logic [7:0]  out_count_reg, out_count_next;
  logic        out_trunc_reg, out_trunc_next;

  logic [31:0] add_s;
  logic        add_co;
  logic        accept;
  logic [7:0]  carries_inc;
  logic [7:0]  count_inc;

  adder32 u_adder (
    .s  (add_s),
    .co (add_co),
    .a  (acc_reg),
    .b  (in_data),
    .ci (1'b0)
  );

  // A pending result only lets a new beat in when it is retiring the same cycle.
  assign in_ready  = (state_reg != DONE) || out_ready;
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  assign carries_inc = (carries_reg == 8'hFF) ? 8'hFF : carries_reg + {7'b0, add_co};
  assign count_inc   = count_reg + 8'd1;

  always_comb begin
    state_next       = state_reg;
    acc_next         = acc_reg;
    carries_next     = carries_reg;
    count_next       = count_reg;
    out_sum_next     = out_sum_reg;
    out_carries_next = out_carries_reg;
    out_count_next   = out_count_reg;
    out_trunc_next   = out_trunc_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == DONE && out_ready) state_next = IDLE;
        if (accept) begin
          acc_next     = in_data;
          carries_next = 8'd0;
          count_next   = 8'd1;
          if (in_last) begin
            state_next       = DONE;
            out_sum_next     = in_data;
            out_carries_next = 8'd0;
            out_count_next   = 8'd1;
            out_trunc_next   = 1'b0;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_next     = add_s;
          carries_next = carries_inc;
          count_next   = count_inc;
          if (in_last || count_inc == MAX_CNT) begin
            state_next       = DONE;
            out_sum_next     = add_s;
            out_carries_next = carries_inc;
            out_count_next   = count_inc;
            out_trunc_next   = !in_last;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      acc_reg         <= 32'd0;
      carries_reg     <= 8'd0;
      count_reg       <= 8'd0;
      out_sum_reg     <= 32'd0;
      out_carries_reg <= 8'd0;
      out_count_reg   <= 8'd0;
      out_trunc_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      carries_reg     <= carries_next;
      count_reg       <= count_next;
      out_sum_reg     <= out_sum_next;
      out_carries_reg <= out_carries_next;
      out_count_reg   <= out_count_next;
      out_trunc_reg   <= out_trunc_next;
    end
  end

  assign out_sum     = out_sum_reg;
  assign out_carries = out_carries_reg;
  assign out_count   = out_count_reg;
  assign out_trunc   = out_trunc_reg;
endmodule

// File: tb/tb_adder32_accum.sv
// Scoreboard bench for adder32_accum: stimulus queues expected packet results,
// a negedge monitor retires them as the DUT hands each result over.
`timescale 1ns/1ps

module tb_adder32_accum;
  localparam int MAX_LEN = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  carries;
    logic [7:0]  count;
    logic        trunc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_carries;
  logic [7:0]  out_count;
  logic        out_trunc;

  logic rand_ready  = 1'b0;
  logic rnd_ready   = 1'b1;
  logic ready_force = 1'b1;

  res_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  assign out_ready = rand_ready ? rnd_ready : ready_force;

  always #5 clk = ~clk;

  adder32_accum #(.MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_count   (out_count),
    .out_trunc   (out_trunc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expect_res(input logic [31:0] s, input int c, input int n, input logic t);
    res_t r;
    r.sum     = s;
    r.carries = 8'(c);
    r.count   = 8'(n);
    r.trunc   = t;
    exp_q.push_back(r);
  endtask

  // Offer one beat from posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      total++;
      $display("FAIL beat_accept: beat %0h not accepted in %0d cycles", d, n);
    end
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one result retires per out_valid && out_ready cycle.
  initial begin
    res_t got;
    res_t exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got.sum     = out_sum;
        got.carries = out_carries;
        got.count   = out_count;
        got.trunc   = out_trunc;
        $display("result sum=%08h carries=%0d count=%0d trunc=%0b", got.sum, got.carries, got.count, got.trunc);
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL result_unexpected: got sum=%08h count=%0d, expected no result", got.sum, got.count);
        end else begin
          exp = exp_q.pop_front();
          if (got === exp) passed++;
          else $display("FAIL result: got sum=%08h carries=%0d count=%0d trunc=%0b, expected sum=%08h carries=%0d count=%0d trunc=%0b",
                        got.sum, got.carries, got.count, got.trunc, exp.sum, exp.carries, exp.count, exp.trunc);
        end
      end
    end
  end

  // Random ready toggling for the random-packet phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    in_last  = 1'b0;
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_carries", out_carries, 0);
    check("rst_out_trunc", out_trunc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    idle(1);

    // Two-beat packet with latency check
    expect_res(32'd530, 0, 2, 1'b0);
    send_beat(32'd520, 1'b0);
    check("no_early_valid", out_valid, 0);
    send_beat(32'd10, 1'b1);
    check("latency_valid", out_valid, 1);
    idle(2);

    // Two carry-outs, wrap to zero
    expect_res(32'h0000_0000, 2, 3, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b1);
    idle(2);

    // MAX_LEN truncation, then the fifth beat starts a fresh single-beat packet
    expect_res(32'd4, 0, 4, 1'b1);
    expect_res(32'd1, 0, 1, 1'b0);
    repeat (4) send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b1);
    idle(2);

    // Backpressure on a pending result, then retire and accept in the same cycle
    ready_force = 1'b0;
    expect_res(32'd5, 0, 1, 1'b0);
    send_beat(32'd5, 1'b1);
    expect_res(32'd7, 0, 1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd7;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum", out_sum, 32'd5);
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    check("no_bubble_valid", out_valid, 1);
    check("no_bubble_sum", out_sum, 32'd7);
    idle(2);

    // Reset mid-packet discards the partial sum
    send_beat(32'd37, 1'b0);
    send_beat(32'd48, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_count", out_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    idle(1);
    expect_res(32'd235, 0, 2, 1'b0);
    send_beat(32'd125, 1'b0);
    send_beat(32'd110, 1'b1);
    idle(2);

    // Random packets against a 64-bit reference sum
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int          len;
      logic [31:0] d[MAX_LEN];
      logic [63:0] t;
      logic [31:0] s;
      int          c;
      len = $urandom_range(1, MAX_LEN);
      for (int b = 0; b < len; b++) d[b] = $urandom;
      s = d[0];
      c = 0;
      for (int b = 1; b < len; b++) begin
        t = {32'd0, s} + {32'd0, d[b]};
        c = c + int'(t[32]);
        s = t[31:0];
      end
      expect_res(s, c, len, 1'b0);
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        send_beat(d[b], b == len - 1);
      end
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      idle(1);
      n++;
    end
    idle(2);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
